fpnew_classifier_pipe: RTL and testbench



---
 rtl/fpnew_classifier_pipe.sv | 227 ++++++++++++++++++++++
 tb/tb_fpnew_classifier_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_classifier_pipe.sv
// fpnew_classifier_pipe: pipelined multi-format FP operand classifier.
// Classifies up to NumOperands FLEN-wide operands per transaction into
// fp_info_t records plus an FCLASS mask for operand 0, then carries the
// result through NumPipeRegs elastic register stages.
// Optional feature macro: FPNEW_NANBOX_CHECK_EN (NaN-boxing check). When it
// is undefined every operand is treated as boxed and the upper bits are ignored.

package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;

endpackage

// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer; ready may depend on downstream ready only through the stage
// chain, never the payload. flush_i and rst_i drop every in-flight beat.
module fpnew_classifier_pipe #(
  parameter int FLEN        = 64,
  parameter int NumOperands = 3,
  parameter int NumPipeRegs = 1,
  parameter int TagWidth    = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [NumOperands-1:0][FLEN-1:0]     operands_i,
  input  logic [2:0]                           fmt_i,
  input  logic [TagWidth-1:0]                  tag_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output fpnew_pkg::fp_info_t [NumOperands-1:0] info_o,
  output logic [9:0]                           fclass_o,
  output logic                                 illegal_fmt_o,
  output logic [TagWidth-1:0]                  tag_o,
  output logic                                 busy_o
);

  localparam int InfoW = NumOperands * 8;
  localparam int PW    = InfoW + 10 + 1 + TagWidth;

  // Returns {sign, info} for one operand interpreted in format fmt.
  function automatic logic [8:0] classify_op(input logic [FLEN-1:0] op,
                                             input logic [2:0]      fmt);
    logic [63:0]         x;
    logic                sign;
    logic                exp_zero;
    logic                exp_ones;
    logic                man_zero;
    logic                man_msb;
    logic                boxed;
    int                  w;
    fpnew_pkg::fp_info_t info;
    x              = '0;
    x[FLEN-1:0]    = op;
    sign           = 1'b0;
    exp_zero       = 1'b0;
    exp_ones       = 1'b0;
    man_zero       = 1'b0;
    man_msb        = 1'b0;
    w              = 0;
    case (fmt)
      3'd0: begin
        sign = x[31]; exp_zero = ~|x[30:23]; exp_ones = &x[30:23];
        man_zero = ~|x[22:0]; man_msb = x[22]; w = 32;
      end
      3'd1: begin
        sign = x[63]; exp_zero = ~|x[62:52]; exp_ones = &x[62:52];
        man_zero = ~|x[51:0]; man_msb = x[51]; w = 64;
      end
      3'd2: begin
        sign = x[15]; exp_zero = ~|x[14:10]; exp_ones = &x[14:10];
        man_zero = ~|x[9:0]; man_msb = x[9]; w = 16;
      end
      3'd3: begin
        sign = x[7]; exp_zero = ~|x[6:2]; exp_ones = &x[6:2];
        man_zero = ~|x[1:0]; man_msb = x[1]; w = 8;
      end
      3'd4: begin
        sign = x[15]; exp_zero = ~|x[14:7]; exp_ones = &x[14:7];
        man_zero = ~|x[6:0]; man_msb = x[6]; w = 16;
      end
      default: begin
        w = 0;
      end
    endcase
`ifdef FPNEW_NANBOX_CHECK_EN
    // Every container bit above the format width must be one.
    boxed = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < FLEN && i >= w && !x[i]) boxed = 1'b0;
    end
`else
    boxed = 1'b1;
`endif
    info.is_normal     = boxed & ~exp_zero & ~exp_ones;
    info.is_zero       = boxed & exp_zero & man_zero;
    info.is_subnormal  = boxed & exp_zero & ~man_zero;
    info.is_inf        = boxed & exp_ones & man_zero;
    info.is_nan        = ~boxed | (exp_ones & ~man_zero);
    info.is_signalling = boxed & info.is_nan & ~man_msb;
    info.is_quiet      = info.is_nan & ~info.is_signalling;
    info.is_boxed      = boxed;
    return {sign, info};
  endfunction

  logic                                  w_illegal;
  fpnew_pkg::fp_info_t [NumOperands-1:0] w_info;
  logic                                  w_sign0;
  logic [9:0]                            w_fclass;
  logic [PW-1:0]                         w_payload;
  logic [PW-1:0]                         w_out_payload;

  // FP64 does not fit a 32-bit container; codes above FP16ALT are unused.
  assign w_illegal = (fmt_i > 3'd4) || ((FLEN < 64) && (fmt_i == 3'd1));

  // Per-operand classification; an illegal format forces every record to 0.
  always_comb begin
    logic [8:0] res;
    w_info  = '0;
    w_sign0 = 1'b0;
    res     = '0;
    for (int k = 0; k < NumOperands; k++) begin
      res = classify_op(operands_i[k], fmt_i);
      if (!w_illegal) begin
        w_info[k] = res[7:0];
        if (k == 0) w_sign0 = res[8];
      end
    end
  end

  // FCLASS one-hot for operand 0; unboxed operands already read as qNaN.
  always_comb begin
    w_fclass = '0;
    if (w_info[0].is_nan) begin
      if (w_info[0].is_signalling) w_fclass[8] = 1'b1;
      else                         w_fclass[9] = 1'b1;
    end else if (w_info[0].is_inf) begin
      if (w_sign0) w_fclass[0] = 1'b1;
      else         w_fclass[7] = 1'b1;
    end else if (w_info[0].is_normal) begin
      if (w_sign0) w_fclass[1] = 1'b1;
      else         w_fclass[6] = 1'b1;
    end else if (w_info[0].is_subnormal) begin
      if (w_sign0) w_fclass[2] = 1'b1;
      else         w_fclass[5] = 1'b1;
    end else if (w_info[0].is_zero) begin
      if (w_sign0) w_fclass[3] = 1'b1;
      else         w_fclass[4] = 1'b1;
    end
  end

  assign w_payload = {w_info, w_fclass, w_illegal, tag_i};
  assign {info_o, fclass_o, illegal_fmt_o, tag_o} = w_out_payload;

  if (NumPipeRegs == 0) begin : g_comb
    assign w_out_payload = w_payload;
    assign out_valid_o   = in_valid_i & ~flush_i;
    assign in_ready_o    = out_ready_i;
    assign busy_o        = 1'b0;
  end else begin : g_pipe
    logic [NumPipeRegs-1:0] r_valid;
    logic [PW-1:0]          r_data [NumPipeRegs];
    logic [NumPipeRegs-1:0] w_stage_ready;
    logic [NumPipeRegs-1:0] w_up_valid;
    logic [PW-1:0]          w_up_data [NumPipeRegs];

    // A stage may load when the output is taken or any stage at or after it is empty.
    always_comb begin
      for (int i = 0; i < NumPipeRegs; i++) begin
        w_stage_ready[i] = out_ready_i;
        for (int j = i; j < NumPipeRegs; j++) begin
          if (!r_valid[j]) w_stage_ready[i] = 1'b1;
        end
      end
    end

    // Upstream view of each stage: the input port for stage 0, the previous stage otherwise.
    always_comb begin
      w_up_valid[0] = in_valid_i;
      w_up_data[0]  = w_payload;
      for (int i = 1; i < NumPipeRegs; i++) begin
        w_up_valid[i] = r_valid[i-1];
        w_up_data[i]  = r_data[i-1];
      end
    end

    // Stage registers: reset clears all, flush drops valids, data holds while stalled.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_valid <= '0;
        for (int i = 0; i < NumPipeRegs; i++) r_data[i] <= '0;
      end else begin
        for (int i = 0; i < NumPipeRegs; i++) begin
          if (w_up_valid[i] && w_stage_ready[i]) r_data[i] <= w_up_data[i];
          if (flush_i)               r_valid[i] <= 1'b0;
          else if (w_stage_ready[i]) r_valid[i] <= w_up_valid[i];
        end
      end
    end

    assign w_out_payload = r_data[NumPipeRegs-1];
    assign out_valid_o   = r_valid[NumPipeRegs-1];
    assign in_ready_o    = w_stage_ready[0];
    assign busy_o        = |r_valid;
  end

endmodule

// File: tb/tb_fpnew_classifier_pipe.sv
// Directed bench for fpnew_classifier_pipe: a 1-stage instance checks
// classification latency and values, a 2-stage instance checks streaming,
// back-pressure, flush and reset behaviour.
module tb_fpnew_classifier_pipe;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             out_ready;
  logic [2:0][63:0] operands;
  logic [2:0]       fmt;
  logic [3:0]       tag;

  logic                          in_ready1, out_valid1, illegal1, busy1;
  fpnew_pkg::fp_info_t [2:0]     info1;
  logic [9:0]                    fclass1;
  logic [3:0]                    tag1;
  logic                          in_ready2, out_valid2, illegal2, busy2;
  fpnew_pkg::fp_info_t [2:0]     info2;
  logic [9:0]                    fclass2;
  logic [3:0]                    tag2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [13:0] exp_q[$];

  localparam logic [63:0] POS_ONE = 64'hFFFFFFFF_3F800000;
  localparam logic [63:0] NEG_ONE = 64'hFFFFFFFF_BF800000;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  fpnew_classifier_pipe #(.FLEN(64), .NumOperands(3), .NumPipeRegs(1), .TagWidth(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .operands_i(operands), .fmt_i(fmt), .tag_i(tag), .out_valid_o(out_valid1),
    .out_ready_i(out_ready), .info_o(info1), .fclass_o(fclass1), .illegal_fmt_o(illegal1),
    .tag_o(tag1), .busy_o(busy1)
  );

  fpnew_classifier_pipe #(.FLEN(64), .NumOperands(3), .NumPipeRegs(2), .TagWidth(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .operands_i(operands), .fmt_i(fmt), .tag_i(tag), .out_valid_o(out_valid2),
    .out_ready_i(out_ready), .info_o(info2), .fclass_o(fclass2), .illegal_fmt_o(illegal2),
    .tag_o(tag2), .busy_o(busy2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    operands = '1; fmt = 3'd0; tag = 4'h0;
    step();
    n_tests++;
    if ({out_valid1, busy1, tag1, fclass1, illegal1, info1} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut1: got v=%b b=%b tag=%h fc=%h ill=%b info=%h, want all 0",
               out_valid1, busy1, tag1, fclass1, illegal1, info1);
    end
    n_tests++;
    if ({out_valid2, busy2, tag2, fclass2, illegal2, info2} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut2: got v=%b b=%b tag=%h fc=%h ill=%b info=%h, want all 0",
               out_valid2, busy2, tag2, fclass2, illegal2, info2);
    end
    rst = 1'b0;
  endtask

  task automatic test_classify();
    logic [63:0] t_op   [11];
    logic [2:0]  t_fmt  [11];
    logic [7:0]  t_info [11];
    logic [9:0]  t_fc   [11];
    logic        t_ill  [11];
    logic [23:0] exp_info;
    logic [7:0]  other;
    t_op[0]  = 64'hFFFFFFFF_3F800000; t_fmt[0]  = 3'd0; t_info[0]  = 8'h81; t_fc[0]  = 10'h040; t_ill[0]  = 1'b0;
    t_op[1]  = 64'h00000000_3F800000; t_fmt[1]  = 3'd0; t_ill[1]  = 1'b0;
`ifdef FPNEW_NANBOX_CHECK_EN
    t_info[1] = 8'h0A; t_fc[1] = 10'h200;
`else
    t_info[1] = 8'h81; t_fc[1] = 10'h040;
`endif
    t_op[2]  = 64'hFFF00000_00000000; t_fmt[2]  = 3'd1; t_info[2]  = 8'h11; t_fc[2]  = 10'h001; t_ill[2]  = 1'b0;
    t_op[3]  = 64'hFFFFFFFF_FFFF7C01; t_fmt[3]  = 3'd2; t_info[3]  = 8'h0D; t_fc[3]  = 10'h100; t_ill[3]  = 1'b0;
    t_op[4]  = 64'hFFFFFFFF_FFFFFF01; t_fmt[4]  = 3'd3; t_info[4]  = 8'h41; t_fc[4]  = 10'h020; t_ill[4]  = 1'b0;
    t_op[5]  = 64'hFFFFFFFF_3F800000; t_fmt[5]  = 3'd5; t_info[5]  = 8'h00; t_fc[5]  = 10'h000; t_ill[5]  = 1'b1;
    t_op[6]  = 64'hFFFFFFFF_FFFF8000; t_fmt[6]  = 3'd4; t_info[6]  = 8'h21; t_fc[6]  = 10'h008; t_ill[6]  = 1'b0;
    t_op[7]  = 64'h7FF80000_00000000; t_fmt[7]  = 3'd1; t_info[7]  = 8'h0B; t_fc[7]  = 10'h200; t_ill[7]  = 1'b0;
    t_op[8]  = 64'hFFFFFFFF_80000001; t_fmt[8]  = 3'd0; t_info[8]  = 8'h41; t_fc[8]  = 10'h004; t_ill[8]  = 1'b0;
    t_op[9]  = 64'hFFFFFFFF_FFFF7C00; t_fmt[9]  = 3'd2; t_info[9]  = 8'h11; t_fc[9]  = 10'h080; t_ill[9]  = 1'b0;
    t_op[10] = 64'hC0000000_00000000; t_fmt[10] = 3'd1; t_info[10] = 8'h81; t_fc[10] = 10'h002; t_ill[10] = 1'b0;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      operands[0] = t_op[k];
      operands[1] = '1;
      operands[2] = '1;
      fmt         = t_fmt[k];
      tag         = 4'(k);
      in_valid    = 1'b1;
      other       = t_ill[k] ? 8'h00 : 8'h0B;
      exp_info    = {other, other, t_info[k]};
      step();
      in_valid = 1'b0;
      n_tests++;
      if (out_valid1 !== 1'b1 || tag1 !== 4'(k) || fclass1 !== t_fc[k] ||
          illegal1 !== t_ill[k] || info1 !== exp_info) begin
        n_fail++;
        $display("FAIL classify_p1[%0d]: got v=%b tag=%h fc=%h ill=%b info=%h, want v=1 tag=%h fc=%h ill=%b info=%h",
                 k, out_valid1, tag1, fclass1, illegal1, info1, 4'(k), t_fc[k], t_ill[k], exp_info);
      end
      step();
      n_tests++;
      if (out_valid2 !== 1'b1 || tag2 !== 4'(k) || fclass2 !== t_fc[k] ||
          illegal2 !== t_ill[k] || info2 !== exp_info || out_valid1 !== 1'b0) begin
        n_fail++;
        $display("FAIL classify_p2[%0d]: got v=%b tag=%h fc=%h ill=%b info=%h v1=%b, want v=1 tag=%h fc=%h ill=%b info=%h v1=0",
                 k, out_valid2, tag2, fclass2, illegal2, info2, out_valid1, 4'(k), t_fc[k], t_ill[k], exp_info);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    fmt = 3'd0;
    operands = '1;
    for (int c = 0; c < 8; c++) begin
      in_valid    = (c < 6);
      tag         = 4'(c + 1);
      operands[0] = POS_ONE;
      #1;
      if (c < 6) begin
        n_tests++;
        if (in_ready2 !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready[%0d]: got %b, want 1", c, in_ready2);
        end
      end
      n_tests++;
      if (out_valid2 !== (c >= 2) || (c >= 2 && tag2 !== 4'(c - 1))) begin
        n_fail++;
        $display("FAIL b2b_out[%0d]: got v=%b tag=%h, want v=%b tag=%h",
                 c, out_valid2, tag2, (c >= 2), 4'(c - 1));
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int          next_tag;
    int          emitted;
    logic        prev_stall;
    logic        saw_not_ready;
    logic [9:0]  held_fc;
    logic [3:0]  held_tag;
    logic [71:0] held_info;
    logic [13:0] front;
    logic [9:0]  fc_now;
    do_reset();
    exp_q.delete();
    next_tag = 1; emitted = 0; prev_stall = 1'b0; saw_not_ready = 1'b0;
    held_fc = '0; held_tag = '0; held_info = '0;
    fmt = 3'd0;
    operands = '1;
    for (int c = 0; c < 40 && emitted < 6; c++) begin
      out_ready   = !(c >= 3 && c <= 6);
      in_valid    = (next_tag <= 6);
      tag         = 4'(next_tag);
      operands[0] = next_tag[0] ? POS_ONE : NEG_ONE;
      fc_now      = next_tag[0] ? 10'h040 : 10'h002;
      #1;
      n_tests++;
      if (in_ready2 !== (exp_q.size() < 2 || out_ready)) begin
        n_fail++;
        $display("FAIL bp_in_ready[%0d]: got %b, want %b (in flight %0d)",
                 c, in_ready2, (exp_q.size() < 2 || out_ready), exp_q.size());
      end
      if (!in_ready2) saw_not_ready = 1'b1;
      n_tests++;
      if (busy2 !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL bp_busy[%0d]: got %b, want %b", c, busy2, (exp_q.size() != 0));
      end
      if (prev_stall) begin
        n_tests++;
        if (out_valid2 !== 1'b1 || tag2 !== held_tag || fclass2 !== held_fc || 72'(info2) !== held_info) begin
          n_fail++;
          $display("FAIL bp_stable[%0d]: got v=%b tag=%h fc=%h, want v=1 tag=%h fc=%h",
                   c, out_valid2, tag2, fclass2, held_tag, held_fc);
        end
      end
      if (out_valid2 && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra[%0d]: got tag=%h, want no output", c, tag2);
        end else begin
          front = exp_q.pop_front();
          if ({fclass2, tag2} !== front) begin
            n_fail++;
            $display("FAIL bp_order[%0d]: got fc=%h tag=%h, want fc=%h tag=%h",
                     c, fclass2, tag2, front[13:4], front[3:0]);
          end
        end
        emitted++;
      end
      if (in_valid && in_ready2) begin
        exp_q.push_back({fc_now, 4'(next_tag)});
        next_tag++;
      end
      prev_stall = out_valid2 && !out_ready;
      held_tag   = tag2;
      held_fc    = fclass2;
      held_info  = 72'(info2);
      step();
    end
    in_valid = 1'b0;
    n_tests++;
    if (emitted != 6 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_complete: got emitted=%0d pending=%0d, want emitted=6 pending=0",
               emitted, exp_q.size());
    end
    n_tests++;
    if (saw_not_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_backpressure: got in_ready never low, want low while full and stalled");
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; fmt = 3'd0; operands = '1; operands[0] = POS_ONE;
    in_valid = 1'b1; tag = 4'd7;
    step();
    tag = 4'd8;
    step();
    n_tests++;
    if (out_valid2 !== 1'b1 || tag2 !== 4'd7 || busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_prefill: got v=%b tag=%h busy=%b, want v=1 tag=7 busy=1", out_valid2, tag2, busy2);
    end
    flush = 1'b1; tag = 4'd9;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_tests++;
    if (out_valid2 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: got v=%b busy=%b, want v=0 busy=0", out_valid2, busy2);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if (out_valid2 !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_ghost[%0d]: got v=1 tag=%h, want v=0", c, tag2);
      end
    end
    in_valid = 1'b1; tag = 4'd10;
    step();
    in_valid = 1'b0;
    step();
    n_tests++;
    if (out_valid2 !== 1'b1 || tag2 !== 4'd10) begin
      n_fail++;
      $display("FAIL flush_recover: got v=%b tag=%h, want v=1 tag=a", out_valid2, tag2);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; fmt = 3'd0; operands = '1; operands[0] = NEG_ONE;
    in_valid = 1'b1; tag = 4'd11;
    step();
    tag = 4'd12;
    step();
    rst = 1'b1; flush = 1'b1; tag = 4'd13;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if ({out_valid2, busy2, tag2, fclass2, illegal2, info2} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_dut2: got v=%b b=%b tag=%h fc=%h ill=%b info=%h, want all 0",
               out_valid2, busy2, tag2, fclass2, illegal2, info2);
    end
    n_tests++;
    if ({out_valid1, busy1, tag1, fclass1, illegal1, info1} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_dut1: got v=%b b=%b tag=%h fc=%h ill=%b info=%h, want all 0",
               out_valid1, busy1, tag1, fclass1, illegal1, info1);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (out_valid2 !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_ghost[%0d]: got v=1 tag=%h, want v=0", c, tag2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    operands = '0; fmt = 3'd0; tag = 4'h0;
    test_reset();
    test_classify();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
